// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - one master port of the DMEM arbiter
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              sext;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;
  logic              err;

  modport master (
    output req, we, size, sext, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, size, sext, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter and sequencer in front of DMEM
module dmem_arbiter #(
  parameter int MEM_SIZE = 1024,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     m0,
  dmem_arbiter_if.slave     m1,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [1:0]        dmem_size,
  output logic              dmem_sext,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_SIZE);

  // Alignment and bounds check; the end address is formed one bit wider so it cannot wrap.
  function automatic logic access_err(input logic [1:0] size, input logic [ADDR_W-1:0] addr);
    logic [ADDR_W:0] nbytes;
    logic [ADDR_W:0] end_addr;
    logic            misaligned;
    case (size)
      2'b00:   nbytes = (ADDR_W+1)'(1);
      2'b01:   nbytes = (ADDR_W+1)'(2);
      2'b10:   nbytes = (ADDR_W+1)'(4);
      default: nbytes = '0;
    endcase
    end_addr   = {1'b0, addr} + nbytes;
    misaligned = (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    return (size == 2'b11) || misaligned || (end_addr > MEM_LIMIT);
  endfunction

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              sext_q, sext_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              dmem_read_q, dmem_read_d;
  logic              dmem_write_q, dmem_write_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [31:0]       rdata0_q, rdata0_d;
  logic [31:0]       rdata1_q, rdata1_d;
  logic              rerr0_q, rerr0_d;
  logic              rerr1_q, rerr1_d;

  logic              pick0, pick1;
  logic              sel_we, sel_sext, sel_err;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;

  // Grant only from IDLE; on a tie the port that did not win last time is chosen.
  always_comb begin
    pick0 = 1'b0;
    pick1 = 1'b0;
    if (state_q == S_IDLE) begin
      if (m0.req && m1.req) begin
        pick0 = last_grant_q;
        pick1 = ~last_grant_q;
      end else begin
        pick0 = m0.req;
        pick1 = m1.req;
      end
    end
  end

  // Steer the winning port's request fields toward the latches.
  always_comb begin
    sel_we    = m0.we;
    sel_size  = m0.size;
    sel_sext  = m0.sext;
    sel_addr  = m0.addr;
    sel_wdata = m0.wdata;
    if (pick1) begin
      sel_we    = m1.we;
      sel_size  = m1.size;
      sel_sext  = m1.sext;
      sel_addr  = m1.addr;
      sel_wdata = m1.wdata;
    end
    sel_err = access_err(sel_size, sel_addr);
  end

  // Sequencer: capture in IDLE, one DMEM cycle in ACCESS, respond in RESP.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    we_d         = we_q;
    size_d       = size_q;
    sext_d       = sext_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    dmem_read_d  = 1'b0;
    dmem_write_d = 1'b0;
    rvalid0_d    = 1'b0;
    rvalid1_d    = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    rerr0_d      = rerr0_q;
    rerr1_d      = rerr1_q;
    case (state_q)
      S_IDLE: begin
        if (pick0 || pick1) begin
          state_d      = S_ACCESS;
          last_grant_d = pick1;
          owner_d      = pick1;
          we_d         = sel_we;
          size_d       = sel_size;
          sext_d       = sel_sext;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          err_d        = sel_err;
          dmem_read_d  = ~sel_we & ~sel_err;
          dmem_write_d = sel_we & ~sel_err;
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
        if (owner_q) begin
          rvalid1_d = 1'b1;
          rdata1_d  = (err_q || we_q) ? 32'h0 : dmem_rdata;
          rerr1_d   = err_q;
        end else begin
          rvalid0_d = 1'b1;
          rdata0_d  = (err_q || we_q) ? 32'h0 : dmem_rdata;
          rerr0_d   = err_q;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      sext_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      err_q        <= 1'b0;
      dmem_read_q  <= 1'b0;
      dmem_write_q <= 1'b0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rdata0_q     <= 32'h0;
      rdata1_q     <= 32'h0;
      rerr0_q      <= 1'b0;
      rerr1_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      size_q       <= size_d;
      sext_q       <= sext_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      dmem_read_q  <= dmem_read_d;
      dmem_write_q <= dmem_write_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      rerr0_q      <= rerr0_d;
      rerr1_q      <= rerr1_d;
    end
  end

  assign m0.gnt    = pick0;
  assign m1.gnt    = pick1;
  assign m0.rvalid = rvalid0_q;
  assign m1.rvalid = rvalid1_q;
  assign m0.rdata  = rdata0_q;
  assign m1.rdata  = rdata1_q;
  assign m0.err    = rerr0_q;
  assign m1.err    = rerr1_q;

  assign dmem_read  = dmem_read_q;
  assign dmem_write = dmem_write_q;
  assign dmem_size  = size_q;
  assign dmem_sext  = sext_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

endmodule
